// File: rtl/adder_seq_ctrl.sv
// Sequencer between the AXI4-Lite register file and the adder datapath: issues operands,
// waits for the result, writes it back to r2. Optional interrupt via ADDER_SEQ_CTRL_IRQ_EN.
module adder_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             ACLK,
    input  logic             ARSTn,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [31:0]      i_r0,
    input  logic [31:0]      i_r1,
    output logic             o_dp_valid,
    input  logic             i_dp_ready,
    output logic [31:0]      o_dp_a,
    output logic [31:0]      o_dp_b,
    output logic             o_dp_op,
    input  logic             i_dp_res_valid,
    input  logic [31:0]      i_dp_res,
    output logic             o_enable_ctrl_write,
    output logic [31:0]      o_busr,
    output logic             o_rst_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_op_count
`ifdef ADDER_SEQ_CTRL_IRQ_EN
    ,
    output logic             o_irq,
    input  logic             i_irq_clr
`endif
);

    // The timer only needs to reach TIMEOUT_CYCLES-1.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_ABORT
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             op_q, op_d;
    logic [31:0]      busr_q, busr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            busr_q    <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            busr_q    <= busr_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Datapath handshake: operands transfer on the cycle where o_dp_valid and
    // i_dp_ready are both high; o_dp_valid never drops and operands never change before that.
    always_comb begin
        state_d             = state_q;
        a_d                 = a_q;
        b_d                 = b_q;
        op_d                = op_q;
        busr_d              = busr_q;
        timer_d             = timer_q;
        timeout_d           = timeout_q;
        count_d             = count_q;
        o_dp_valid          = 1'b0;
        o_enable_ctrl_write = 1'b0;
        o_rst_start         = 1'b0;
        o_done              = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d       = i_r0;
                    b_d       = i_r1;
                    op_d      = i_op;
                    timeout_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_dp_valid = 1'b1;
                if (i_dp_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A result arriving on the final timer cycle still wins over the abort.
                if (i_dp_res_valid) begin
                    busr_d  = i_dp_res;
                    state_d = ST_WRITE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WRITE: begin
                o_enable_ctrl_write = 1'b1;
                o_rst_start         = 1'b1;
                o_done              = 1'b1;
                count_d             = count_q + CNT_W'(1);
                state_d             = ST_IDLE;
            end
            ST_ABORT: begin
                o_rst_start = 1'b1;
                timeout_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_dp_a     = a_q;
    assign o_dp_b     = b_q;
    assign o_dp_op    = op_q;
    assign o_busr     = busr_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_timeout  = timeout_q;
    assign o_op_count = count_q;

`ifdef ADDER_SEQ_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Setting has priority so a completion is never lost to a concurrent clear.
    always_comb begin
        irq_d = irq_q;
        if (state_q == ST_WRITE || state_q == ST_ABORT) begin
            irq_d = 1'b1;
        end else if (i_irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: register-file start bit model, datapath model
// and a result scoreboard. Covers the interrupt when ADDER_SEQ_CTRL_IRQ_EN is defined.
module tb_adder_seq_ctrl;

    localparam int TO = 4;
    localparam int CW = 3;

    logic          ACLK = 1'b0;
    logic          ARSTn = 1'b0;
    logic          start_bit;
    logic          set_start = 1'b0;
    logic          op_in;
    logic [31:0]   r0, r1;
    logic          dp_ready, res_valid;
    logic [31:0]   dp_res;
    logic          irq_clr = 1'b0;

    logic          o_dp_valid, o_dp_op, o_enable_ctrl_write, o_rst_start;
    logic          o_busy, o_done, o_timeout;
    logic [31:0]   o_dp_a, o_dp_b, o_busr;
    logic [CW-1:0] o_op_count;
`ifdef ADDER_SEQ_CTRL_IRQ_EN
    logic          o_irq;
`endif

    int            total = 0;
    int            bad = 0;
    logic [31:0]   exp_q[$];
    logic [CW-1:0] exp_count = '0;
    logic          exp_timeout = 1'b0;
    logic [31:0]   last_busr = '0;

    adder_seq_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .ACLK(ACLK), .ARSTn(ARSTn),
        .i_start(start_bit), .i_op(op_in), .i_r0(r0), .i_r1(r1),
        .o_dp_valid(o_dp_valid), .i_dp_ready(dp_ready),
        .o_dp_a(o_dp_a), .o_dp_b(o_dp_b), .o_dp_op(o_dp_op),
        .i_dp_res_valid(res_valid), .i_dp_res(dp_res),
        .o_enable_ctrl_write(o_enable_ctrl_write), .o_busr(o_busr),
        .o_rst_start(o_rst_start), .o_busy(o_busy), .o_done(o_done),
        .o_timeout(o_timeout), .o_op_count(o_op_count)
`ifdef ADDER_SEQ_CTRL_IRQ_EN
        , .o_irq(o_irq), .i_irq_clr(irq_clr)
`endif
    );

    always #5 ACLK = ~ACLK;

    // Register-file start bit: set by software, cleared by the sequencer.
    always @(posedge ACLK) begin
        if (!ARSTn) start_bit <= 1'b0;
        else if (set_start) start_bit <= 1'b1;
        else if (o_rst_start) start_bit <= 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full operation. res_wait >= TO means the datapath never answers.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int ready_wait, input int res_wait, input bit clr_on_write);
        logic [31:0] exp_res;
        logic [31:0] popped;
        int k;
        bit ended;
        @(negedge ACLK);
        r0 = a; r1 = b; op_in = op; set_start = 1'b1; dp_ready = 1'b0; res_valid = 1'b0;
        @(negedge ACLK);
        set_start = 1'b0;
        @(negedge ACLK);
        total++;
        if (o_dp_valid !== 1'b1 || o_dp_a !== a || o_dp_b !== b || o_dp_op !== op || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL issue: valid=%0b a=%h b=%h op=%0b busy=%0b, want valid=1 a=%h b=%h op=%0b busy=1",
                     o_dp_valid, o_dp_a, o_dp_b, o_dp_op, o_busy, a, b, op);
        end
        total++;
        if (o_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: timeout=%0b want 0", o_timeout);
        end
        exp_timeout = 1'b0;
        r0 = $urandom; r1 = $urandom; op_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < ready_wait; i++) begin
            res_valid = 1'($urandom_range(0, 1));
            dp_res = $urandom;
            @(negedge ACLK);
            total++;
            if (o_dp_valid !== 1'b1 || o_dp_a !== a || o_dp_b !== b || o_dp_op !== op ||
                o_timeout !== 1'b0 || o_enable_ctrl_write !== 1'b0) begin
                bad++;
                $display("FAIL issue_hold[%0d]: valid=%0b a=%h b=%h op=%0b to=%0b wr=%0b, want 1 %h %h %0b 0 0",
                         i, o_dp_valid, o_dp_a, o_dp_b, o_dp_op, o_timeout, o_enable_ctrl_write, a, b, op);
            end
        end
        res_valid = 1'b0;
        dp_ready = 1'b1;
        @(negedge ACLK);
        dp_ready = 1'b0;
        total++;
        if (o_dp_valid !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL wait_state: valid=%0b busy=%0b want 0 1", o_dp_valid, o_busy);
        end
        exp_res = op ? (a - b) : (a + b);
        ended = 1'b0;
        k = 0;
        while (!ended && k < TO + 3) begin
            if (k == res_wait) begin
                res_valid = 1'b1;
                dp_res = o_dp_op ? (o_dp_a - o_dp_b) : (o_dp_a + o_dp_b);
                exp_q.push_back(exp_res);
            end
            @(negedge ACLK);
            res_valid = 1'b0;
            if (o_enable_ctrl_write === 1'b1 || o_rst_start === 1'b1) ended = 1'b1;
            else k++;
        end
        if (!ended) begin
            total++; bad++;
            $display("FAIL end_bound: no write-back or abort within %0d cycles", TO + 3);
        end else if (res_wait < TO) begin
            total++;
            if (k !== res_wait) begin
                bad++;
                $display("FAIL write_latency: wait cycles=%0d want %0d", k, res_wait);
            end
            total++;
            if (o_enable_ctrl_write !== 1'b1 || o_rst_start !== 1'b1 || o_done !== 1'b1) begin
                bad++;
                $display("FAIL write_pulses: wr=%0b rst=%0b done=%0b want 1 1 1",
                         o_enable_ctrl_write, o_rst_start, o_done);
            end
            total++;
            popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            if (o_busr !== popped) begin
                bad++;
                $display("FAIL busr: got %h want %h", o_busr, popped);
            end
            if (clr_on_write) irq_clr = 1'b1;
            exp_count = exp_count + 1'b1;
            last_busr = popped;
        end else begin
            total++;
            if (k !== TO - 1) begin
                bad++;
                $display("FAIL abort_latency: wait cycles before abort=%0d want %0d", k + 1, TO);
            end
            total++;
            if (o_enable_ctrl_write !== 1'b0 || o_done !== 1'b0 || o_rst_start !== 1'b1) begin
                bad++;
                $display("FAIL abort_pulses: wr=%0b done=%0b rst=%0b want 0 0 1",
                         o_enable_ctrl_write, o_done, o_rst_start);
            end
            exp_timeout = 1'b1;
        end
        @(negedge ACLK);
        irq_clr = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_op_count !== exp_count || o_timeout !== exp_timeout ||
            o_busr !== last_busr || o_rst_start !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL post: busy=%0b cnt=%0d to=%0b busr=%h rst=%0b done=%0b, want 0 %0d %0b %h 0 0",
                     o_busy, o_op_count, o_timeout, o_busr, o_rst_start, o_done,
                     exp_count, exp_timeout, last_busr);
        end
        @(negedge ACLK);
        total++;
        if (o_busy !== 1'b0 || o_dp_valid !== 1'b0) begin
            bad++;
            $display("FAIL retrigger: busy=%0b valid=%0b want 0 0", o_busy, o_dp_valid);
        end
    endtask

    task automatic test_reset();
        ARSTn = 1'b0;
        repeat (2) @(negedge ACLK);
        total++;
        if ({o_dp_valid, o_dp_op, o_enable_ctrl_write, o_rst_start, o_busy, o_done, o_timeout} !== 7'd0 ||
            o_dp_a !== 32'd0 || o_dp_b !== 32'd0 || o_busr !== 32'd0 || o_op_count !== '0) begin
            bad++;
            $display("FAIL reset: valid=%0b busy=%0b a=%h b=%h busr=%h cnt=%0d to=%0b want all 0",
                     o_dp_valid, o_busy, o_dp_a, o_dp_b, o_busr, o_op_count, o_timeout);
        end
`ifdef ADDER_SEQ_CTRL_IRQ_EN
        total++;
        if (o_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: irq=%0b want 0", o_irq);
        end
`endif
        ARSTn = 1'b1;
    endtask

    task automatic test_basic();
        do_op(32'd5, 32'd7, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_ready_stall();
        do_op(32'h1234_5678, 32'h0000_1111, 1'b0, 10, 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_op(32'd9, 32'd3, 1'b1, 0, 99, 1'b0);
    endtask

    task automatic test_last_cycle();
        do_op(32'd100, 32'd58, 1'b1, 2, TO - 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        r0 = 32'hAAAA_0000; r1 = 32'h0000_5555; op_in = 1'b0; set_start = 1'b1; dp_ready = 1'b1;
        @(negedge ACLK);
        set_start = 1'b0;
        repeat (2) @(negedge ACLK);
        total++;
        if (o_busy !== 1'b1 || o_dp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait: busy=%0b valid=%0b want 1 0", o_busy, o_dp_valid);
        end
        ARSTn = 1'b0;
        dp_ready = 1'b0;
        @(negedge ACLK);
        total++;
        if ({o_dp_valid, o_dp_op, o_enable_ctrl_write, o_rst_start, o_busy, o_done, o_timeout} !== 7'd0 ||
            o_dp_a !== 32'd0 || o_dp_b !== 32'd0 || o_busr !== 32'd0 || o_op_count !== '0) begin
            bad++;
            $display("FAIL mid_reset: busy=%0b rst=%0b wr=%0b a=%h busr=%h cnt=%0d want all 0",
                     o_busy, o_rst_start, o_enable_ctrl_write, o_dp_a, o_busr, o_op_count);
        end
        ARSTn = 1'b1;
        exp_count = '0;
        exp_timeout = 1'b0;
        last_busr = '0;
        do_op(32'd1, 32'd2, 1'b0, 0, 0, 1'b0);
        total++;
        if (o_busr !== 32'd3) begin
            bad++;
            $display("FAIL after_reset_busr: got %h want 00000003", o_busr);
        end
    endtask

    // Enough completions to carry the counter through its wrap.
    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, TO - 1), 1'b0);
        end
    endtask

`ifdef ADDER_SEQ_CTRL_IRQ_EN
    task automatic test_irq();
        @(negedge ACLK);
        irq_clr = 1'b1;
        @(negedge ACLK);
        irq_clr = 1'b0;
        total++;
        if (o_irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear_pre: irq=%0b want 0", o_irq);
        end
        do_op(32'd20, 32'd22, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge ACLK);
        total++;
        if (o_irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_held: irq=%0b want 1", o_irq);
        end
        irq_clr = 1'b1;
        @(negedge ACLK);
        irq_clr = 1'b0;
        total++;
        if (o_irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr: irq=%0b want 0", o_irq);
        end
        do_op(32'd4, 32'd4, 1'b0, 0, 1, 1'b1);
        total++;
        if (o_irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set_wins: irq=%0b want 1", o_irq);
        end
    endtask
`endif

    initial begin
        op_in = 1'b0; r0 = '0; r1 = '0; dp_ready = 1'b0; res_valid = 1'b0; dp_res = '0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_timeout();
        test_last_cycle();
        test_reset_mid();
        test_back_to_back();
`ifdef ADDER_SEQ_CTRL_IRQ_EN
        test_irq();
`endif
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d results never written back, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
